// File: rtl/digest_streamer.sv
// Streams a captured 256-bit hash digest out as eight 32-bit words.
// Ports: clk/RST, digest+start in, m_data/m_valid/m_ready/m_last out, busy/done/overrun status.
module digest_streamer #(
    parameter int BYTE_SWAP = 0
) (
    input  logic         clk,
    input  logic         RST,
    input  logic [255:0] digest,
    input  logic         start,
    output logic [31:0]  m_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         m_last,
    output logic         busy,
    output logic         done,
    output logic         overrun
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t         state_q;
    logic [2:0]     idx_q;
    logic [255:0]   snap_q;
    logic           done_q;
    logic           ovr_q;

    logic           hs;
    logic           at_last;
    logic [31:0]    word_raw;
    logic [31:0]    word_fmt;

    // Valid comes only from registered state, never from m_ready.
    assign m_valid = (state_q == SEND);
    assign at_last = (idx_q == 3'd7);
    assign hs      = m_valid & m_ready;

    // Word i sits at snap[255-32i -: 32]; ~idx equals 7-idx.
    assign word_raw = snap_q[{~idx_q, 5'b0} +: 32];

    generate
        if (BYTE_SWAP != 0) begin : g_swap
            assign word_fmt = {word_raw[7:0],   word_raw[15:8],
                               word_raw[23:16], word_raw[31:24]};
        end else begin : g_noswap
            assign word_fmt = word_raw;
        end
    endgenerate

    assign m_data  = m_valid ? word_fmt : 32'h0;
    assign m_last  = m_valid & at_last;
    assign busy    = m_valid;
    assign done    = done_q;
    assign overrun = ovr_q;

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            snap_q  <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ovr_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        snap_q  <= digest;
                        idx_q   <= 3'd0;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (hs && at_last) begin
                        done_q <= 1'b1;
                        idx_q  <= 3'd0;
                        // Back-to-back start on the final handshake chains
                        // straight into a new transfer without a gap.
                        if (start) begin
                            snap_q <= digest;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        if (hs) begin
                            idx_q <= idx_q + 3'd1;
                        end
                        if (start) begin
                            ovr_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digest_streamer.sv
// Directed bench for digest_streamer: table-driven stream plus
// hand-written sequences for backpressure, overrun, chaining and reset.
module tb_digest_streamer;

    logic         clk;
    logic         RST;
    logic [255:0] digest;
    logic         start;
    logic         m_ready;

    logic [31:0]  m_data, m_data_sw;
    logic         m_valid, m_valid_sw;
    logic         m_last, m_last_sw;
    logic         busy, busy_sw;
    logic         done, done_sw;
    logic         overrun, overrun_sw;

    int errors;
    int checks;

    digest_streamer #(.BYTE_SWAP(0)) dut (
        .clk(clk), .RST(RST), .digest(digest), .start(start),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .busy(busy), .done(done), .overrun(overrun)
    );

    digest_streamer #(.BYTE_SWAP(1)) dut_sw (
        .clk(clk), .RST(RST), .digest(digest), .start(start),
        .m_data(m_data_sw), .m_valid(m_valid_sw), .m_ready(m_ready),
        .m_last(m_last_sw), .busy(busy_sw), .done(done_sw),
        .overrun(overrun_sw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] W [8];
    logic [255:0] abc;
    logic [255:0] ones;

    typedef struct {
        logic        start;
        logic        ready;
        logic        e_valid;
        logic [31:0] e_data;
        logic        e_last;
        logic        e_busy;
        logic        e_done;
        logic        e_ovr;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic pulse_start(input logic [255:0] d);
        @(negedge clk);
        digest = d;
        start = 1'b1;
        m_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [31:0] prev_data;
        logic        prev_stall;
        int          got;
        bit          seen_done;

        errors = 0;
        checks = 0;
        W = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
              32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
        abc = {W[0], W[1], W[2], W[3], W[4], W[5], W[6], W[7]};
        ones = {8{32'h11111111}};

        // Reset has priority over start and m_ready.
        RST = 1'b1;
        start = 1'b1;
        m_ready = 1'b1;
        digest = abc;
        repeat (2) @(negedge clk);
        check("rst_valid", {31'b0, m_valid}, 32'h0);
        check("rst_data", m_data, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_flags", {29'b0, m_last, done, overrun}, 32'h0);
        RST = 1'b0;
        start = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {31'b0, m_valid}, 32'h0);

        // Basic stream table: outputs expected while row inputs are applied.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++)
            tbl[i+1] = '{1'b0, 1'b1, 1'b1, W[i], (i == 7), 1'b1,
                         1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int r = 0; r < 11; r++) begin
            @(negedge clk);
            start = tbl[r].start;
            m_ready = tbl[r].ready;
            #1;
            check($sformatf("tbl%0d_valid", r), {31'b0, m_valid},
                  {31'b0, tbl[r].e_valid});
            check($sformatf("tbl%0d_data", r), m_data, tbl[r].e_data);
            check($sformatf("tbl%0d_last", r), {31'b0, m_last},
                  {31'b0, tbl[r].e_last});
            check($sformatf("tbl%0d_busy", r), {31'b0, busy},
                  {31'b0, tbl[r].e_busy});
            check($sformatf("tbl%0d_done", r), {31'b0, done},
                  {31'b0, tbl[r].e_done});
            check($sformatf("tbl%0d_ovr", r), {31'b0, overrun},
                  {31'b0, tbl[r].e_ovr});
            check($sformatf("tbl%0d_swdata", r), m_data_sw,
                  tbl[r].e_valid ? bswap(tbl[r].e_data) : 32'h0);
        end
        start = 1'b0;
        m_ready = 1'b0;

        // Backpressure with digest scrambled every cycle after capture.
        pulse_start(abc);
        got = 0;
        seen_done = 0;
        prev_stall = 0;
        prev_data = '0;
        for (int c = 0; c < 300 && !seen_done; c++) begin
            digest = {8{$urandom}};
            m_ready = 1'($urandom_range(0, 1));
            #1;
            if (prev_stall) begin
                check("bp_hold_valid", {31'b0, m_valid}, 32'h1);
                check("bp_hold_data", m_data, prev_data);
            end
            if (done) begin
                seen_done = 1;
                check("bp_count", got, 8);
            end else if (m_valid && m_ready) begin
                if (got < 8) begin
                    check($sformatf("bp_word%0d", got), m_data, W[got]);
                    check($sformatf("bp_last%0d", got), {31'b0, m_last},
                          {31'b0, got == 7});
                end
                got++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data = m_data;
            @(negedge clk);
        end
        if (!seen_done) begin
            errors++;
            checks++;
            $display("FAIL bp_timeout: got words=%0d expected done", got);
        end
        m_ready = 1'b0;

        // Overrun: start at index 3 is ignored and pulses overrun once.
        pulse_start(abc);
        for (int k = 0; k < 8; k++) begin
            m_ready = 1'b1;
            start = (k == 3);
            digest = (k == 3) ? ones : abc;
            #1;
            check($sformatf("ov_word%0d", k), m_data, W[k]);
            check($sformatf("ov_flag%0d", k), {31'b0, overrun},
                  {31'b0, k == 4});
            @(negedge clk);
        end
        start = 1'b0;
        m_ready = 1'b0;
        #1;
        check("ov_done", {31'b0, done}, 32'h1);
        check("ov_end_valid", {31'b0, m_valid}, 32'h0);

        // Back-to-back: start on the final handshake chains a new digest.
        pulse_start(abc);
        for (int k = 0; k < 8; k++) begin
            m_ready = 1'b1;
            start = (k == 7);
            digest = (k == 7) ? ones : abc;
            #1;
            check($sformatf("bb_word%0d", k), m_data, W[k]);
            @(negedge clk);
        end
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            m_ready = 1'b1;
            #1;
            check($sformatf("bb2_valid%0d", k), {31'b0, m_valid}, 32'h1);
            check($sformatf("bb2_word%0d", k), m_data, 32'h11111111);
            check($sformatf("bb2_done%0d", k), {31'b0, done},
                  {31'b0, k == 0});
            check($sformatf("bb2_ovr%0d", k), {31'b0, overrun}, 32'h0);
            @(negedge clk);
        end
        m_ready = 1'b0;
        #1;
        check("bb_done", {31'b0, done}, 32'h1);
        check("bb_idle", {31'b0, m_valid}, 32'h0);

        // Reset at index 4 aborts without done; restart begins at H0.
        pulse_start(abc);
        for (int k = 0; k < 4; k++) begin
            m_ready = 1'b1;
            #1;
            check($sformatf("rm_word%0d", k), m_data, W[k]);
            @(negedge clk);
        end
        RST = 1'b1;
        #1;
        check("rm_word4", m_data, W[4]);
        @(negedge clk);
        RST = 1'b0;
        m_ready = 1'b0;
        #1;
        check("rm_valid", {31'b0, m_valid}, 32'h0);
        check("rm_busy", {31'b0, busy}, 32'h0);
        check("rm_done", {31'b0, done}, 32'h0);
        check("rm_data", m_data, 32'h0);
        @(negedge clk);
        check("rm_done2", {31'b0, done}, 32'h0);
        pulse_start(abc);
        #1;
        check("rm_restart", m_data, W[0]);
        check("rm_restart_sw", m_data_sw, bswap(W[0]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
